// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: pixel-generation stage for the VGA pipeline.
// Converts controller counters to active-area coordinates (stage 1), then
// draws a bouncing square over a background colour (stage 2). The sync
// signals travel through both stages so they stay aligned with RGB.
// The square moves once per frame, on the single cycle where both counters
// are zero, which is always in blanking.
// Optional feature: define VGA_BORDER_EN to draw a one-pixel white border
// around the active area (the border wins over the square).
module vga_bounce_renderer #(
   parameter int DATA_WIDTH = 4,
   parameter int H_OFFSET   = 144,
   parameter int V_OFFSET   = 31,
   parameter int ACTIVE_W   = 640,
   parameter int ACTIVE_H   = 480,
   parameter int BOX_SIZE   = 32,
   parameter int STEP       = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [9:0]              hCounter,
   input  logic [9:0]              vCounter,
   input  logic                    hSyncIn,
   input  logic                    vSyncIn,
   input  logic                    vidOnIn,
   input  logic                    pause,
   input  logic [3*DATA_WIDTH-1:0] boxColor,
   input  logic [3*DATA_WIDTH-1:0] bgColor,
   output logic [DATA_WIDTH-1:0]   red,
   output logic [DATA_WIDTH-1:0]   green,
   output logic [DATA_WIDTH-1:0]   blue,
   output logic                    hSyncOut,
   output logic                    vSyncOut,
   output logic [9:0]              boxX,
   output logic [9:0]              boxY,
   output logic [7:0]              frameCount
);

   localparam int CW = 3 * DATA_WIDTH;

   // Motion limits and sizes in the 11-bit arithmetic domain, so that sums
   // such as box+BOX_SIZE or box+STEP never wrap.
   localparam logic [10:0] X_MAX  = 11'(ACTIVE_W - BOX_SIZE);
   localparam logic [10:0] Y_MAX  = 11'(ACTIVE_H - BOX_SIZE);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

   // Direction of travel on one axis.
   typedef enum logic {
      MOVE_POS = 1'b0,
      MOVE_NEG = 1'b1
   } dir_e;

   // Position and direction of one axis, stepped together.
   typedef struct packed {
      logic [9:0] pos;
      dir_e       dir;
   } axis_t;

   // One frame of motion on one axis: advance by STEP, clamping to the
   // wall and reversing when the wall is reached or passed.
   function automatic axis_t step_axis(input axis_t cur, input logic [10:0] lim);
      axis_t       nxt;
      logic [10:0] sum;
      nxt = cur;
      sum = {1'b0, cur.pos} + STEP_W;
      if (cur.dir == MOVE_POS) begin
         if (sum >= lim) begin
            nxt.pos = lim[9:0];
            nxt.dir = MOVE_NEG;
         end else begin
            nxt.pos = sum[9:0];
         end
      end else begin
         if ({1'b0, cur.pos} <= STEP_W) begin
            nxt.pos = '0;
            nxt.dir = MOVE_POS;
         end else begin
            nxt.pos = cur.pos - STEP_W[9:0];
         end
      end
      return nxt;
   endfunction

   // ------------------------------------------------------------------
   // Stage 1: active-area coordinates plus registered control signals
   // ------------------------------------------------------------------
   logic [9:0] x_d, x_q;
   logic [9:0] y_d, y_q;
   logic       vid_on1_d, vid_on1_q;
   logic       hsync1_d, hsync1_q;
   logic       vsync1_d, vsync1_q;

   // Stage-1 next values: subtract the blanking offsets (wrap is harmless,
   // vidOn masks everything outside the active area).
   always_comb begin
      x_d       = hCounter - 10'(H_OFFSET);
      y_d       = vCounter - 10'(V_OFFSET);
      vid_on1_d = vidOnIn;
      hsync1_d  = hSyncIn;
      vsync1_d  = vSyncIn;
   end

   // Stage-1 register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         vid_on1_q <= 1'b0;
         hsync1_q  <= 1'b0;
         vsync1_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the
         // pre-edge value, so stage ordering within a block cannot matter.
         x_q       <= x_d;
         y_q       <= y_d;
         vid_on1_q <= vid_on1_d;
         hsync1_q  <= hsync1_d;
         vsync1_q  <= vsync1_d;
      end
   end

   // ------------------------------------------------------------------
   // Motion: per-axis direction FSMs, positions and frame counter
   // ------------------------------------------------------------------
   dir_e       dir_x_d, dir_x_q;
   dir_e       dir_y_d, dir_y_q;
   logic [9:0] box_x_d, box_x_q;
   logic [9:0] box_y_d, box_y_q;
   logic [7:0] frame_cnt_d, frame_cnt_q;
   logic       frame_tick;
   axis_t      axis_x_n;
   axis_t      axis_y_n;

   assign frame_tick = (hCounter == '0) && (vCounter == '0);

   // Motion next-state: only a frame tick changes anything; pause freezes
   // position and direction but the frame counter keeps counting.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      box_x_d     = box_x_q;
      box_y_d     = box_y_q;
      frame_cnt_d = frame_cnt_q;
      axis_x_n    = step_axis('{pos: box_x_q, dir: dir_x_q}, X_MAX);
      axis_y_n    = step_axis('{pos: box_y_q, dir: dir_y_q}, Y_MAX);
      if (frame_tick) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
         if (!pause) begin
            box_x_d = axis_x_n.pos;
            dir_x_d = axis_x_n.dir;
            box_y_d = axis_y_n.pos;
            dir_y_d = axis_y_n.dir;
         end
      end
   end

   // Motion state register: square restarts at the top-left heading
   // right and down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_x_q     <= MOVE_POS;
         dir_y_q     <= MOVE_POS;
         box_x_q     <= '0;
         box_y_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: colour selection and sync alignment
   // ------------------------------------------------------------------
   logic [CW-1:0] rgb_d, rgb_q;
   logic          hsync2_d, hsync2_q;
   logic          vsync2_d, vsync2_q;
   logic          in_box;
   logic          on_border;

   // Square hit test in 11 bits so box+BOX_SIZE cannot wrap.
   assign in_box = ({1'b0, x_q} >= {1'b0, box_x_q}) &&
                   ({1'b0, x_q} <  ({1'b0, box_x_q} + BOX_W)) &&
                   ({1'b0, y_q} >= {1'b0, box_y_q}) &&
                   ({1'b0, y_q} <  ({1'b0, box_y_q} + BOX_W));

`ifdef VGA_BORDER_EN
   assign on_border = (x_q == '0) || (x_q == 10'(ACTIVE_W - 1)) ||
                      (y_q == '0) || (y_q == 10'(ACTIVE_H - 1));
`else
   assign on_border = 1'b0;
`endif

   // Stage-2 colour mux: blank outside active video, border over square
   // over background; colours are taken live from the inputs.
   always_comb begin
      rgb_d    = '0;
      hsync2_d = hsync1_q;
      vsync2_d = vsync1_q;
      if (vid_on1_q) begin
         if (on_border) begin
            rgb_d = '1;
         end else if (in_box) begin
            rgb_d = boxColor;
         end else begin
            rgb_d = bgColor;
         end
      end
   end

   // Stage-2 output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q    <= '0;
         hsync2_q <= 1'b0;
         vsync2_q <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         hsync2_q <= hsync2_d;
         vsync2_q <= vsync2_d;
      end
   end

   assign red        = rgb_q[CW-1 -: DATA_WIDTH];
   assign green      = rgb_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
   assign blue       = rgb_q[DATA_WIDTH-1:0];
   assign hSyncOut   = hsync2_q;
   assign vSyncOut   = vsync2_q;
   assign boxX       = box_x_q;
   assign boxY       = box_y_q;
   assign frameCount = frame_cnt_q;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb_vga_bounce_renderer: scoreboard bench for vga_bounce_renderer.
// Each driven pixel pushes its expected {R,G,B,hSync,vSync}; the entry is
// popped and compared two clocks later. Square position and frame count
// are tracked by a behavioural model and also checked against fixed values
// at the bounce points. Honours VGA_BORDER_EN when computing expectations.
module tb_vga_bounce_renderer;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [9:0]    hCounter, vCounter;
   logic          hSyncIn, vSyncIn, vidOnIn, pause;
   logic [3*DW-1:0] boxColor, bgColor;
   logic [DW-1:0] red, green, blue;
   logic          hSyncOut, vSyncOut;
   logic [9:0]    boxX, boxY;
   logic [7:0]    frameCount;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [13:0] exp_q[$];

   // Behavioural model of the square.
   int m_bx, m_by, m_dx, m_dy, m_fc;

   always #20 clk = ~clk;

   vga_bounce_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .hCounter   (hCounter),
      .vCounter   (vCounter),
      .hSyncIn    (hSyncIn),
      .vSyncIn    (vSyncIn),
      .vidOnIn    (vidOnIn),
      .pause      (pause),
      .boxColor   (boxColor),
      .bgColor    (bgColor),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hSyncOut   (hSyncOut),
      .vSyncOut   (vSyncOut),
      .boxX       (boxX),
      .boxY       (boxY),
      .frameCount (frameCount)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_fc = 0;
   endtask

   // Frame-tick behaviour of the model.
   task automatic model_motion(input int h, input int v);
      if (h == 0 && v == 0) begin
         m_fc = (m_fc + 1) % 256;
         if (!pause) begin
            if (m_dx > 0) begin
               if (m_bx + 2 >= 608) begin m_bx = 608; m_dx = -1; end
               else m_bx = m_bx + 2;
            end else begin
               if (m_bx <= 2) begin m_bx = 0; m_dx = 1; end
               else m_bx = m_bx - 2;
            end
            if (m_dy > 0) begin
               if (m_by + 2 >= 448) begin m_by = 448; m_dy = -1; end
               else m_by = m_by + 2;
            end else begin
               if (m_by <= 2) begin m_by = 0; m_dy = 1; end
               else m_by = m_by - 2;
            end
         end
      end
   endtask

   function automatic logic [13:0] model_pixel(input int h, input int v, input logic vid,
                                               input logic hs, input logic vs);
      int          x, y;
      logic [11:0] c;
      x = (h - 144) & 1023;
      y = (v - 31) & 1023;
      if (!vid) c = 12'h000;
`ifdef VGA_BORDER_EN
      else if (x == 0 || x == 639 || y == 0 || y == 479) c = 12'hFFF;
`endif
      else if (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) c = boxColor;
      else c = bgColor;
      return {c, hs, vs};
   endfunction

   // One pixel clock: drive, predict, clock, then compare the entry whose
   // result has just reached the outputs.
   task automatic drive(input int h, input int v, input logic hs, input logic vs, input logic vid);
      logic [13:0] e;
      hCounter = 10'(h);
      vCounter = 10'(v);
      hSyncIn  = hs;
      vSyncIn  = vs;
      vidOnIn  = vid;
      model_motion(h, v);
      exp_q.push_back(model_pixel(h, v, vid, hs, vs));
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check("pixel", {18'b0, red, green, blue, hSyncOut, vSyncOut}, {18'b0, e});
      end
      check("boxX", {22'b0, boxX}, m_bx);
      check("boxY", {22'b0, boxY}, m_by);
      check("frameCount", {24'b0, frameCount}, m_fc);
   endtask

   task automatic idle();
      drive(5, 5, 1'b0, 1'b0, 1'b0);
   endtask

   // Frame tick followed by a pixel well inside the square.
   task automatic tick();
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      drive(144 + m_bx + 5, 31 + m_by + 5, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check(tag, {18'b0, red, green, blue, hSyncOut, vSyncOut}, 32'd0);
   endtask

   // Reset held across active stimulus; outputs must be zero at once and
   // stay zero; pipeline restarts with an empty scoreboard.
   task automatic do_reset();
      reset    = 1'b1;
      hCounter = 10'd200;
      vCounter = 10'd100;
      hSyncIn  = 1'b1;
      vSyncIn  = 1'b1;
      vidOnIn  = 1'b1;
      #1;
      check_zero_outputs("reset_rgb_sync");
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset_hold_rgb_sync");
      check("reset_boxX", {22'b0, boxX}, 0);
      check("reset_boxY", {22'b0, boxY}, 0);
      check("reset_frameCount", {24'b0, frameCount}, 0);
      reset = 1'b0;
      exp_q.delete();
      model_reset();
   endtask

   initial begin
      reset    = 1'b1;
      pause    = 1'b0;
      boxColor = 12'hF80;
      bgColor  = 12'h00F;
      hCounter = '0;
      vCounter = '0;
      hSyncIn  = 1'b0;
      vSyncIn  = 1'b0;
      vidOnIn  = 1'b0;
      model_reset();

      do_reset();

      // First pixel after reset: background, two clocks later.
      drive(200, 100, 1'b0, 1'b0, 1'b1);
      drive(201, 100, 1'b0, 1'b0, 1'b1);
      idle();

      // Sync edges in isolation and together.
      drive(300, 50, 1'b0, 1'b0, 1'b0);
      drive(300, 50, 1'b1, 1'b0, 1'b0);
      drive(300, 50, 1'b1, 1'b0, 1'b0);
      drive(300, 50, 1'b0, 1'b1, 1'b0);
      drive(300, 50, 1'b1, 1'b1, 1'b0);
      drive(300, 50, 1'b0, 1'b0, 1'b0);

      // First frame tick moves the square to (2,2).
      tick();
      check("tick1_boxX", {22'b0, boxX}, 2);
      check("tick1_boxY", {22'b0, boxY}, 2);
      check("tick1_frameCount", {24'b0, frameCount}, 1);
      drive(146, 33, 1'b0, 1'b0, 1'b1);  // top-left corner of square
      drive(178, 33, 1'b0, 1'b0, 1'b1);  // x=34: just right of square
      drive(177, 64, 1'b0, 1'b0, 1'b1);  // bottom-right inside corner
      drive(177, 65, 1'b0, 1'b0, 1'b1);  // one line below square
      idle();

      // Run to both bounces.
      for (int t = 2; t <= 305; t++) begin
         tick();
         if (t == 224) check("tick224_boxY", {22'b0, boxY}, 448);
         if (t == 225) check("tick225_boxY", {22'b0, boxY}, 446);
         if (t == 304) check("tick304_boxX", {22'b0, boxX}, 608);
      end
      check("tick305_boxX", {22'b0, boxX}, 606);
      check("tick305_boxY", {22'b0, boxY}, 286);
      check("tick305_frameCount", {24'b0, frameCount}, 49);
      drive(144 + 639, 31 + 479, 1'b1, 1'b0, 1'b1);  // bottom-right active pixel
      drive(144 + 605, 31 + 300, 1'b0, 1'b1, 1'b1);  // just left of square

      // Paused ticks: position frozen, frame counter advances.
      pause = 1'b1;
      repeat (3) tick();
      check("pause_boxX", {22'b0, boxX}, 606);
      check("pause_boxY", {22'b0, boxY}, 286);
      check("pause_frameCount", {24'b0, frameCount}, 52);
      pause = 1'b0;

      // Blanked in-box pixel, border-column pixel, off-screen counters.
      drive(144 + m_bx + 3, 31 + m_by + 3, 1'b0, 1'b0, 1'b0);
      drive(144, 200, 1'b0, 1'b0, 1'b1);
      drive(10, 5, 1'b1, 1'b1, 1'b0);

      // New colours after a blank pixel, so nothing in flight sees the change.
      idle();
      boxColor = 12'h5A3;
      bgColor  = 12'h0C0;
      drive(144 + m_bx + 10, 31 + m_by + 10, 1'b0, 1'b0, 1'b1);
      drive(144 + 20, 31 + 20, 1'b0, 1'b0, 1'b1);

      // Mid-frame reset: square restarts from the corner.
      drive(400, 200, 1'b1, 1'b0, 1'b1);
      do_reset();
      tick();
      check("post_reset_boxX", {22'b0, boxX}, 2);
      check("post_reset_frameCount", {24'b0, frameCount}, 1);
      drive(150, 40, 1'b0, 1'b1, 1'b1);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_bounce_renderer.md
Name: vga_bounce_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA sync/counter controller, in the divided 25 MHz pixel-clock domain.
- Consumes hCounter/vCounter/hSync/vSync/vidOn and produces RGB for the DAC/pins.
- Draws a solid square over a background colour; the square moves once per frame and bounces off the active-area edges.
- Sync outputs are delayed to stay aligned with the 2-stage pixel pipeline.

Parameters:
- DATA_WIDTH, 4, bits per colour channel
- H_OFFSET, 144, hCounter value of the first active column
- V_OFFSET, 31, vCounter value of the first active row
- ACTIVE_W, 640, active width in pixels
- ACTIVE_H, 480, active height in lines
- BOX_SIZE, 32, square side length in pixels
- STEP, 2, pixels moved per frame on each axis

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset
- hCounter  in  10  horizontal counter from controller
- vCounter  in  10  vertical counter from controller
- hSyncIn  in  1  horizontal sync from controller
- vSyncIn  in  1  vertical sync from controller
- vidOnIn  in  1  active-video flag from controller
- pause  in  1  freeze square motion when high
- boxColor  in  3*DATA_WIDTH  {R,G,B} colour of the square
- bgColor  in  3*DATA_WIDTH  {R,G,B} background colour
- red  out  DATA_WIDTH  red channel
- green  out  DATA_WIDTH  green channel
- blue  out  DATA_WIDTH  blue channel
- hSyncOut  out  1  hSyncIn delayed 2 cycles
- vSyncOut  out  1  vSyncIn delayed 2 cycles
- boxX  out  10  current square left edge, active-area coordinates
- boxY  out  10  current square top edge, active-area coordinates
- frameCount  out  8  frame-tick counter, wraps 255->0

Behaviour:
- Clock is clk. reset is asynchronous and active-high.
- Reset values:
  - red, green, blue, hSyncOut, vSyncOut = 0; all pipeline registers = 0.
  - boxX = boxY = 0; dirX = right; dirY = down; frameCount = 0.
- Stage 1 (registered):
  - x = hCounter - H_OFFSET, y = vCounter - V_OFFSET, 10-bit, truncated.
  - vidOnIn, hSyncIn and vSyncIn are registered alongside x and y.
- Stage 2 (registered outputs):
  - inBox = (x >= boxX) && (x < boxX+BOX_SIZE) && (y >= boxY) && (y < boxY+BOX_SIZE). Compares use 11-bit sums, so no wrap.
  - RGB = 0 when stage-1 vidOn = 0; else boxColor if inBox; else bgColor.
  - hSyncOut/vSyncOut take their stage-1 copies.
- Latency: every output is exactly 2 clk after its input sample. Sync polarity passes through unchanged.
- Frame tick: the single cycle where hCounter == 0 and vCounter == 0, sampled at the input (blanking, so it never tears the visible square).
- Motion FSM, per axis (states MOVE_POS / MOVE_NEG), evaluated only on a frame tick with pause = 0:
  - X axis, XMAX = ACTIVE_W - BOX_SIZE (608):
    - MOVE_POS: if boxX+STEP >= XMAX then boxX = XMAX and go to MOVE_NEG; else boxX += STEP.
    - MOVE_NEG: if boxX <= STEP then boxX = 0 and go to MOVE_POS; else boxX -= STEP.
  - Y axis: identical, with YMAX = ACTIVE_H - BOX_SIZE (448).
  - Arithmetic is 11-bit internally; boxX/boxY never exceed XMAX/YMAX.
- frameCount increments on every frame tick, regardless of pause.
- pause = 1 on a frame tick: position and direction hold; square still drawn.
- Counter values outside the active area: x/y wrap but vidOn = 0, so RGB = 0.
- Reset mid-frame: outputs go to 0 immediately; normal output resumes 2 cycles after first post-reset input. Square restarts at (0,0).
- boxColor/bgColor are sampled combinationally at stage 2. A change takes effect on the next pixel.

Optional Feature:
- Macro VGA_BORDER_EN.
- Defined: in stage 2, pixels with x == 0, x == ACTIVE_W-1, y == 0 or y == ACTIVE_H-1 (and vidOn = 1) output all-ones on every channel. Border has priority over the square. Latency unchanged.
- Undefined: no border logic; edge pixels follow the normal square/background rule.

Test Plan:
- Reset, then drive hCounter=200, vCounter=100, vidOnIn=1, bgColor=12'h00F -> red/green/blue = 0/0/F exactly 2 clk later; all outputs 0 during reset.
- Toggle hSyncIn 0->1 at cycle N -> hSyncOut goes 0->1 at cycle N+2; same for vSyncIn/vSyncOut.
- After reset, one frame tick with pause=0 -> boxX=2, boxY=2, frameCount=1. Pixel hCounter=146, vCounter=33 -> boxColor; hCounter=178 (x=34) -> bgColor.
- 304 frame ticks from reset -> boxX=608, dirX=neg; tick 305 -> boxX=606. Tick 224 -> boxY=448; tick 225 -> boxY=446.
- pause=1 across 3 frame ticks -> boxX/boxY unchanged, frameCount +3. vidOnIn=0 with inBox coordinates -> RGB = 0.
- VGA_BORDER_EN defined: hCounter=144, vCounter=200, vidOnIn=1 -> RGB = F/F/F. Undefined: same stimulus -> bgColor.
